// File: rtl/wb_pkg.sv
// Shared types and helpers for the posted write-back buffer between the
// data cache eviction path and BRAM port B.
package wb_pkg;
  localparam int BLOCK_BITS        = 128;
  localparam int WORD_BITS         = 32;
  localparam int WORDS_PER_BLOCK   = 4;
  // Entry address field is sized for the widest supported memory; narrower
  // configurations zero-extend so stored and probed addresses stay comparable.
  localparam int MAX_BLK_ADDR_BITS = 28;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic                         valid;
    logic [MAX_BLK_ADDR_BITS-1:0] addr;
    logic [BLOCK_BITS-1:0]        data;
  } wb_entry_t;

  function automatic logic [WORD_BITS-1:0] block_word(input logic [BLOCK_BITS-1:0] blk,
                                                      input logic [1:0]            k);
    return blk[WORD_BITS*k +: WORD_BITS];
  endfunction
endpackage

// File: rtl/wb_entry_fifo.sv
// Block storage for the write-back buffer: FIFO pointers, occupancy flags
// and the address lookup used by the refill path.
module wb_entry_fifo
  import wb_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int DEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  push,
  input  logic [ADDR_BITS-5:0]  push_addr,
  input  logic [BLOCK_BITS-1:0] push_block,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  head_valid,
  output logic [ADDR_BITS-5:0]  head_addr,
  output logic [BLOCK_BITS-1:0] head_block,
  output logic                  next_valid,
  output logic [ADDR_BITS-5:0]  next_addr,
  output logic [BLOCK_BITS-1:0] next_block,
  input  logic [ADDR_BITS-5:0]  lookup_addr,
  output logic                  lookup_hit,
  output logic [BLOCK_BITS-1:0] lookup_block
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BA_W  = ADDR_BITS - 4;

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, nxt_ptr, idx;
  logic [CNT_W-1:0] count, count_nxt;
  logic             push_ok;

  assign push_ok = push && !full;
  assign nxt_ptr = rd_ptr + PTR_W'(1);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)
      count_nxt = count + CNT_W'(1);
    else if (!push_ok && pop)
      count_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++)
        entries[i].valid <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        entries[rd_ptr].valid <= 1'b0;
        rd_ptr                <= nxt_ptr;
      end
      if (push_ok) begin
        entries[wr_ptr] <= '{valid: 1'b1,
                             addr:  MAX_BLK_ADDR_BITS'(push_addr),
                             data:  push_block};
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      // A push against a full buffer is lost even if a pop frees a slot now.
      if (push && full)
        overflow <= 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  assign head_valid = entries[rd_ptr].valid;
  assign head_addr  = entries[rd_ptr].addr[BA_W-1:0];
  assign head_block = entries[rd_ptr].data;
  assign next_valid = entries[nxt_ptr].valid;
  assign next_addr  = entries[nxt_ptr].addr[BA_W-1:0];
  assign next_block = entries[nxt_ptr].data;

  // Walk oldest to newest starting at wr_ptr so the newest match wins.
  always_comb begin
    lookup_hit   = 1'b0;
    lookup_block = '0;
    idx          = '0;
    for (int j = 0; j < DEPTH; j++) begin
      idx = wr_ptr + PTR_W'(j);
      if (entries[idx].valid &&
          entries[idx].addr == MAX_BLK_ADDR_BITS'(lookup_addr)) begin
        lookup_hit   = 1'b1;
        lookup_block = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/writeback_buffer.sv
// Posted write-back buffer: takes whole dirty blocks in one cycle and drains
// them to BRAM port B as four word writes, in FIFO order.
module writeback_buffer
  import wb_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int DEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_push,
  input  logic [ADDR_BITS-5:0]  i_push_addr,
  input  logic [BLOCK_BITS-1:0] i_push_block,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
  input  logic                  i_ready_mm,
  output logic [3:0]            o_mem_we,
  output logic [ADDR_BITS-1:0]  o_mem_addr,
  output logic [WORD_BITS-1:0]  o_mem_data,
  input  logic [ADDR_BITS-5:0]  i_lookup_addr,
  output logic                  o_lookup_hit,
  output logic [BLOCK_BITS-1:0] o_lookup_block
);
  localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_BLOCK - 1);

  wb_state_e             state;
  logic [1:0]            k;
  logic                  pop;
  logic                  head_valid, next_valid;
  logic [ADDR_BITS-5:0]  head_addr, next_addr;
  logic [BLOCK_BITS-1:0] head_block, next_block;

  wb_entry_fifo #(
    .ADDR_BITS (ADDR_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .nrst         (nrst),
    .push         (i_push),
    .push_addr    (i_push_addr),
    .push_block   (i_push_block),
    .pop          (pop),
    .full         (o_full),
    .empty        (o_empty),
    .overflow     (o_overflow),
    .head_valid   (head_valid),
    .head_addr    (head_addr),
    .head_block   (head_block),
    .next_valid   (next_valid),
    .next_addr    (next_addr),
    .next_block   (next_block),
    .lookup_addr  (i_lookup_addr),
    .lookup_hit   (o_lookup_hit),
    .lookup_block (o_lookup_block)
  );

  // The last word of the head block completes this cycle.
  assign pop = (state == DRAIN) && i_ready_mm && (k == LAST_WORD);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      k          <= 2'd0;
      o_mem_we   <= 4'h0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_mem_we <= 4'h0;
          if (head_valid) begin
            state      <= DRAIN;
            k          <= 2'd0;
            o_mem_we   <= 4'hF;
            o_mem_addr <= {head_addr, 2'd0, 2'b00};
            o_mem_data <= block_word(head_block, 2'd0);
          end
        end
        DRAIN: begin
          if (i_ready_mm) begin
            if (k == LAST_WORD) begin
              k <= 2'd0;
              // Chain straight into the next block without an idle bubble.
              if (next_valid) begin
                o_mem_addr <= {next_addr, 2'd0, 2'b00};
                o_mem_data <= block_word(next_block, 2'd0);
              end else begin
                state    <= IDLE;
                o_mem_we <= 4'h0;
              end
            end else begin
              k          <= k + 2'd1;
              o_mem_addr <= {head_addr, k + 2'd1, 2'b00};
              o_mem_data <= block_word(head_block, k + 2'd1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          o_mem_we <= 4'h0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_writeback_buffer.sv
// Directed scoreboard bench for writeback_buffer: expected word writes are
// queued at push time and retired by a write monitor on the falling edge.
module tb_writeback_buffer;
  logic         clk;
  logic         nrst;
  logic         i_push;
  logic [7:0]   i_push_addr;
  logic [127:0] i_push_block;
  logic         o_full, o_empty, o_overflow;
  logic         i_ready_mm;
  logic [3:0]   o_mem_we;
  logic [11:0]  o_mem_addr;
  logic [31:0]  o_mem_data;
  logic [7:0]   i_lookup_addr;
  logic         o_lookup_hit;
  logic [127:0] o_lookup_block;

  int n_cmp = 0;
  int n_err = 0;
  logic [43:0] sb [$];
  logic [31:0] mem_obs [logic [11:0]];

  writeback_buffer #(.ADDR_BITS(12), .DEPTH(2)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .i_push         (i_push),
    .i_push_addr    (i_push_addr),
    .i_push_block   (i_push_block),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_overflow     (o_overflow),
    .i_ready_mm     (i_ready_mm),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_data     (o_mem_data),
    .i_lookup_addr  (i_lookup_addr),
    .o_lookup_hit   (o_lookup_hit),
    .o_lookup_block (o_lookup_block)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_block(input logic [7:0] a, input logic [127:0] blk);
    for (int w = 0; w < 4; w++) begin
      logic [1:0] wk;
      wk = 2'(w);
      sb.push_back({a, wk, 2'b00, blk[32*w +: 32]});
    end
  endtask

  // Called at posedge+1; registers the push on the next rising edge.
  task automatic push_blk(input logic [7:0] a, input logic [127:0] blk, input bit accepted);
    i_push       = 1'b1;
    i_push_addr  = a;
    i_push_block = blk;
    if (accepted) expect_block(a, blk);
    @(posedge clk); #1;
    i_push       = 1'b0;
  endtask

  task automatic align;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while (!(sb.size() == 0 && o_mem_we === 4'h0 && o_empty === 1'b1) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, {sb.size() == 0, o_empty, o_mem_we}, {1'b1, 1'b1, 4'h0});
  endtask

  // Write monitor: a write completes on the next rising edge when we && ready.
  always @(negedge clk) begin
    if (o_mem_we === 4'hF && i_ready_mm === 1'b1) begin
      chk("write_was_expected", 128'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        logic [43:0] e;
        e = sb.pop_front();
        chk("mem_write", {o_mem_addr, o_mem_data}, 128'(e));
      end
      mem_obs[o_mem_addr] = o_mem_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  localparam logic [127:0] BLK_3A = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
  localparam logic [127:0] BLK_10 = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
  localparam logic [127:0] BLK_20 = {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
  localparam logic [127:0] BLK_30 = {32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
  localparam logic [127:0] BLK_S  = {32'h5A5A_0003, 32'h5A5A_0002, 32'h5A5A_0001, 32'h5A5A_0000};
  localparam logic [127:0] BLK_55A = {32'h55AA_0003, 32'h55AA_0002, 32'h55AA_0001, 32'h55AA_0000};
  localparam logic [127:0] BLK_55B = {32'h55BB_0003, 32'h55BB_0002, 32'h55BB_0001, 32'h55BB_0000};
  localparam logic [127:0] BLK_77 = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};

  initial begin
    logic [127:0] blk;
    nrst          = 1'b0;
    i_push        = 1'b0;
    i_push_addr   = '0;
    i_push_block  = '0;
    i_ready_mm    = 1'b1;
    i_lookup_addr = 8'h3A;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;

    // Reset state
    chk("rst_full",     128'(o_full),     128'd0);
    chk("rst_empty",    128'(o_empty),    128'd1);
    chk("rst_overflow", 128'(o_overflow), 128'd0);
    chk("rst_we",       128'(o_mem_we),   128'd0);
    chk("rst_addr",     128'(o_mem_addr), 128'd0);
    chk("rst_data",     128'(o_mem_data), 128'd0);
    chk("rst_lookup",   {127'(o_lookup_block), o_lookup_hit}, 128'd0);

    // Single block, ready held high
    push_blk(8'h3A, BLK_3A, 1'b1);
    chk("t1_lookup_hit", {o_lookup_block, o_lookup_hit} >> 0, {BLK_3A, 1'b1} >> 0);
    @(negedge clk);
    chk("t1_latency_we", 128'(o_mem_we), 128'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_we_stream", 128'(o_mem_we), 128'hF);
    end
    @(negedge clk);
    chk("t1_done_we",    128'(o_mem_we), 128'd0);
    chk("t1_done_empty", 128'(o_empty),  128'd1);
    chk("t1_sb_empty",   128'(sb.size()), 128'd0);

    // Back-to-back blocks, full and overflow, no bubble between blocks
    align;
    push_blk(8'h10, BLK_10, 1'b1);
    push_blk(8'h20, BLK_20, 1'b1);
    chk("t2_full", 128'(o_full), 128'd1);
    push_blk(8'h30, BLK_30, 1'b0);
    chk("t2_overflow", 128'(o_overflow), 128'd1);
    chk("t2_full_hold", 128'(o_full), 128'd1);
    i_lookup_addr = 8'h20;
    #1;
    chk("t2_lookup_hit",   128'(o_lookup_hit), 128'd1);
    chk("t2_lookup_block", o_lookup_block,     BLK_20);
    i_lookup_addr = 8'h30;
    #1;
    chk("t2_lookup_dropped", 128'(o_lookup_hit), 128'd0);
    i_lookup_addr = 8'h20;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t2_no_gap", 128'(o_mem_we), 128'hF);
    end
    @(negedge clk);
    chk("t2_end_we",        128'(o_mem_we),     128'd0);
    chk("t2_lookup_popped", 128'(o_lookup_hit), 128'd0);
    chk("t2_end_sb",        128'(sb.size()),    128'd0);

    // Back-pressure while word 2 is presented
    align;
    push_blk(8'h10, BLK_S, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    i_ready_mm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_addr", 128'(o_mem_addr), 128'h108);
      chk("t3_stall_data", 128'(o_mem_data), 128'h5A5A_0002);
      chk("t3_stall_we",   128'(o_mem_we),   128'hF);
      @(posedge clk);
    end
    #1;
    i_ready_mm = 1'b1;
    @(negedge clk);
    chk("t3_resume_addr", 128'(o_mem_addr), 128'h108);
    wait_drain("t3_drain");

    // Duplicate address: newest data wins for lookup and in memory
    align;
    push_blk(8'h55, BLK_55A, 1'b1);
    push_blk(8'h55, BLK_55B, 1'b1);
    i_lookup_addr = 8'h55;
    #1;
    chk("t4_dup_hit",   128'(o_lookup_hit), 128'd1);
    chk("t4_dup_block", o_lookup_block,     BLK_55B);
    wait_drain("t4_drain");
    blk = BLK_55B;
    for (int w = 0; w < 4; w++) begin
      logic [11:0] ma;
      ma = 12'h550 + 12'(4 * w);
      chk("t4_mem_final", 128'(mem_obs[ma]), 128'(blk[32*w +: 32]));
    end

    // Reset during word 1 of a drain
    align;
    chk("t5_overflow_sticky", 128'(o_overflow), 128'd1);
    push_blk(8'h77, BLK_77, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    chk("t5_pre_rst_addr", 128'(o_mem_addr), 128'h774);
    nrst       = 1'b0;
    i_ready_mm = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    nrst       = 1'b1;
    i_ready_mm = 1'b1;
    chk("t5_rst_we",       128'(o_mem_we),   128'd0);
    chk("t5_rst_empty",    128'(o_empty),    128'd1);
    chk("t5_rst_overflow", 128'(o_overflow), 128'd0);
    chk("t5_rst_addr",     128'(o_mem_addr), 128'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_no_write", 128'(o_mem_we), 128'd0);
    end
    chk("t5_sb_empty", 128'(sb.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Posted write-back buffer between the data cache's eviction path and the BRAM write port (port B).
- Accepts whole evicted 128-bit dirty blocks in one cycle, so the cache controller can start its refill immediately.
- Drains each block to memory as four 32-bit word writes in the background.
- Provides a combinational block-address lookup so a refill can be served from a block that has not yet drained.

Parameters:
- ADDR_BITS, 12, byte-address width of the memory (matches the cache).
- DEPTH, 2, number of block entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- nrst  in  1  reset, synchronous, active-low.
- i_push  in  1  enqueue request for an evicted block.
- i_push_addr  in  ADDR_BITS-4  block base address (byte address >> 4).
- i_push_block  in  128  block data; word k = bits [32k+31:32k].
- o_full  out  1  registered; count == DEPTH.
- o_empty  out  1  registered; count == 0.
- o_overflow  out  1  sticky; a push was attempted while o_full.
- i_ready_mm  in  1  memory accepts a write this cycle.
- o_mem_we  out  4  byte write enables to BRAM.
- o_mem_addr  out  ADDR_BITS  word byte address.
- o_mem_data  out  32  write data.
- i_lookup_addr  in  ADDR_BITS-4  block address probed by the refill path.
- o_lookup_hit  out  1  combinational; probed block is held in a valid entry.
- o_lookup_block  out  128  combinational; data of the matching entry.

Behaviour:
- Reset (nrst low at the clock edge):
  - all entries invalid; rd_ptr, wr_ptr and count = 0; word counter = 0.
  - FSM returns to IDLE.
  - o_full=0, o_empty=1, o_overflow=0, o_mem_we=0, o_mem_addr=0, o_mem_data=0.
  - A reset asserted mid-drain aborts the drain. The partially written block is lost, and that loss is accepted.
- Push:
  - Accepted when i_push && !o_full. The entry at wr_ptr is written, marked valid, and wr_ptr increments modulo DEPTH.
  - Push while o_full is dropped and sets o_overflow. This holds even if a pop completes in the same cycle.
- Count:
  - count' = count + push_accepted - pop.
  - A simultaneous push and pop leaves count unchanged.
- FSM states:
  - IDLE: if the rd_ptr entry is valid, go to DRAIN with word counter k=0. The first write appears the cycle after the push is registered, i.e. 1-cycle minimum latency.
  - DRAIN: o_mem_we=4'hF, o_mem_addr={entry.addr, k[1:0], 2'b00}, o_mem_data=entry word k. All three are registered.
    - When i_ready_mm=1, the write completes and k increments.
    - When i_ready_mm=0, the outputs hold and k is unchanged.
    - When the word-3 write completes: pop the entry (clear valid, rd_ptr++), k=0, then go to DRAIN if the next entry is valid, else IDLE. There is no idle bubble between back-to-back blocks.
  - In IDLE, o_mem_we=0.
- Pointer wrap: rd_ptr and wr_ptr wrap from DEPTH-1 to 0. Full and empty are decided by count, not by comparing pointers.
- Lookup:
  - Compares i_lookup_addr against every valid entry, including the entry currently draining.
  - With multiple matches, the most recently pushed entry wins.
  - No match gives o_lookup_hit=0 and o_lookup_block=0.
  - A block pushed in cycle N is visible to lookup from cycle N+1.
- Duplicate addresses: a push to an address already buffered is allowed. Memory ends up holding the newer data because the drain is in FIFO order.

Decomposition:
- Shared package wb_pkg:
  - BLOCK_BITS=128, WORD_BITS=32, WORDS_PER_BLOCK=4.
  - drain-state encoding IDLE/DRAIN.
  - entry record: valid, addr[ADDR_BITS-5:0], data[127:0].
- One sub-module, wb_entry_fifo: storage, pointers, count, full/empty and the lookup comparators.
- The drain FSM and memory-output registers live in writeback_buffer.

Test Plan:
- Reset, push addr 8'h3A with block {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, i_ready_mm=1:
  - writes appear on 4 consecutive cycles to 12'h3A0, 3A4, 3A8, 3AC with data AAAA_0000, BBBB_0001, CCCC_0002, DDDD_0003 and we=F.
  - Afterwards o_empty=1.
- Push two blocks back-to-back (addr 8'h10, 8'h20):
  - o_full=1 after the second push; a third push sets o_overflow=1 and is dropped.
  - Exactly 8 writes follow with no gap, the 12'h100-block first.
- Hold i_ready_mm=0 for 5 cycles mid-drain at k=2:
  - o_mem_addr stays 12'h108, data and we are held.
  - Draining resumes with k=2 when ready returns.
- Lookup 8'h20 while that block is buffered → o_lookup_hit=1 with the exact block.
- Lookup 8'h20 one cycle after its word-3 write → o_lookup_hit=0.
- Push 8'h55 twice with different data → lookup returns the second block; memory at 12'h550..55C finally holds the second block.
- Assert nrst=0 for one cycle during k=1 of a drain → next cycle o_mem_we=0, o_empty=1, o_overflow=0, and no further writes occur.
